// File: rtl/wb2mm_pkg.sv
// Shared types and constants for the Wishbone-to-mm bridge.
package wb2mm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    localparam logic [31:0] WB2MM_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb2mm_if.sv
// Bus bundle for wb2mm: Wishbone pipelined slave side plus the legacy mm side.
// The slave modport is the bridge's view; the master modport is the
// upstream Wishbone master together with the downstream mm peripheral.
interface wb2mm_if #(
    parameter int ADDRLEN = 32,
    parameter int DATALEN = 32
);
    logic                 wb_cyc;
    logic                 wb_stb;
    logic                 wb_we;
    logic [ADDRLEN-1:0]   wb_addr;
    logic [DATALEN-1:0]   wb_dat_i;
    logic [DATALEN/8-1:0] wb_sel;
    logic                 wb_stall;
    logic                 wb_ack;
    logic [DATALEN-1:0]   wb_dat_o;

    logic [31:0]          a;
    logic [31:0]          d;
    logic                 we;
    logic                 rd;
    logic [31:0]          spo;
    logic                 ready;
    logic                 irq;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_i, wb_sel, spo, ready,
        output wb_stall, wb_ack, wb_dat_o, a, d, we, rd, irq
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_dat_i, wb_sel, spo, ready,
        input  wb_stall, wb_ack, wb_dat_o, a, d, we, rd, irq
    );

endinterface

// File: rtl/wb2mm_fifo.sv
// Request FIFO: registered pointers and count, head word falls through.
// Flush empties the FIFO in one cycle and takes priority over push/pop.
module wb2mm_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Next pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb2mm.sv
// Wishbone B4 pipelined slave to single-outstanding mm bus bridge.
// Optional WB2MM_TIMEOUT_EN adds a WAIT-state timeout that acks with
// WB2MM_TIMEOUT_DATA, pulses irq and drains the stuck mm transaction.
//
// state   | meaning
// IDLE    | no mm transaction outstanding; issue FIFO head when mm ready
// WAIT    | mm transaction in flight; first cycle ignores ready
// DRAIN   | timed out; wait for mm ready without acking
module wb2mm
    import wb2mm_pkg::*;
#(
    parameter int ADDRLEN        = 32,
    parameter int DATALEN        = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic     clk,
    input logic     rst,
    wb2mm_if.slave  bus
);
    state_e             state_q, state_d;
    logic               first_q, first_d;
    logic               abort_q, abort_d;
    logic               cur_we_q, cur_we_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        d_q, d_d;
    logic               ack_q, ack_d;
    logic [DATALEN-1:0] dat_q, dat_d;

    req_t               head, push_req;
    logic [REQ_W-1:0]   head_raw;
    logic [$clog2(FIFO_DEPTH):0] unused_count;
    logic               full, empty, push, flush, issue;
    logic               unused_sel;

`ifdef WB2MM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               irq_q, irq_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    assign unused_sel = ^bus.wb_sel;
    assign push_req   = '{we: bus.wb_we, addr: 32'(bus.wb_addr), data: 32'(bus.wb_dat_i)};
    assign head       = req_t'(head_raw);
    assign push       = bus.wb_cyc && bus.wb_stb && !full;
    // Dropping cyc abandons everything not yet issued.
    assign flush      = !bus.wb_cyc;
    assign issue      = (state_q == S_IDLE) && !empty && bus.ready && bus.wb_cyc;

    wb2mm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (issue),
        .flush_i (flush),
        .head_o  (head_raw),
        .count_o (unused_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // The strobe is combinational so a request can issue the cycle after accept;
    // a/d show the head during the pulse and hold it afterwards.
    assign bus.a        = issue ? head.addr : a_q;
    assign bus.d        = issue ? head.data : d_q;
    assign bus.rd       = issue && !head.we;
    assign bus.we       = issue && head.we;
    assign bus.wb_stall = full;
    assign bus.wb_ack   = ack_q;
    assign bus.wb_dat_o = dat_q;
`ifdef WB2MM_TIMEOUT_EN
    assign bus.irq      = irq_q;
`else
    assign bus.irq      = 1'b0;
`endif

    // Issue FSM: next state, captured request and registered ack.
    always_comb begin
        state_d  = state_q;
        first_d  = 1'b0;
        abort_d  = abort_q;
        cur_we_d = cur_we_q;
        a_d      = a_q;
        d_d      = d_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;
`ifdef WB2MM_TIMEOUT_EN
        irq_d    = 1'b0;
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (issue) begin
                    a_d      = head.addr;
                    d_d      = head.data;
                    cur_we_d = head.we;
                    first_d  = 1'b1;
                    state_d  = S_WAIT;
`ifdef WB2MM_TIMEOUT_EN
                    cnt_d    = CW'(1);
`endif
                end
            end
            S_WAIT: begin
                if (!bus.wb_cyc) abort_d = 1'b1;
                if (!first_q && bus.ready) begin
                    if (!abort_q && bus.wb_cyc) begin
                        ack_d = 1'b1;
                        dat_d = cur_we_q ? '0 : DATALEN'(bus.spo);
                    end
                    abort_d = 1'b0;
                    state_d = S_IDLE;
                end
`ifdef WB2MM_TIMEOUT_EN
                else if (cnt_q == TO_CNT) begin
                    if (!abort_q && bus.wb_cyc) begin
                        ack_d = 1'b1;
                        dat_d = DATALEN'(WB2MM_TIMEOUT_DATA);
                    end
                    irq_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
`ifdef WB2MM_TIMEOUT_EN
                if (bus.ready) begin
                    abort_d = 1'b0;
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            first_q  <= 1'b0;
            abort_q  <= 1'b0;
            cur_we_q <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
`ifdef WB2MM_TIMEOUT_EN
            irq_q    <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            abort_q  <= abort_d;
            cur_we_q <= cur_we_d;
            a_q      <= a_d;
            d_q      <= d_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
`ifdef WB2MM_TIMEOUT_EN
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb2mm.sv
// Directed testbench for wb2mm with a behavioural mm slave and bus monitor.
module tb_wb2mm;
    localparam int TC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    wb2mm_if #(.ADDRLEN(32), .DATALEN(32)) bus ();

    wb2mm #(
        .ADDRLEN        (32),
        .DATALEN        (32),
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // mm slave model controls
    int          slv_wait = 1;
    bit          slv_hold = 1'b0;
    bit          slv_hang = 1'b0;
    bit          pend = 1'b0;
    int          wcnt = 0;
    int          rise_cyc = 0;
    logic [31:0] nxt = '0;
    logic [31:0] rdq[$];

    // observation logs
    logic [31:0] p_addr[$];
    logic [31:0] p_data[$];
    bit          p_we[$];
    int          p_cyc[$];
    logic [31:0] ack_dat[$];
    int          ack_cyc[$];
    int          irq_cyc[$];

    // mm slave: ready low for slv_wait cycles after each strobe, then returns data.
    initial begin
        bus.ready = 1'b1;
        bus.spo   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                bus.ready = 1'b1;
            end else if (pend) begin
                if (wcnt > 0) begin
                    bus.ready = 1'b0;
                    wcnt--;
                end else if (!slv_hang) begin
                    bus.ready = 1'b1;
                    bus.spo = nxt;
                    pend = 1'b0;
                    rise_cyc = cyc_cnt;
                end else begin
                    bus.ready = 1'b0;
                end
            end else begin
                bus.ready = !slv_hold;
            end
            #2;
            if (bus.rd || bus.we) begin
                p_addr.push_back(bus.a);
                p_data.push_back(bus.d);
                p_we.push_back(bus.we);
                p_cyc.push_back(cyc_cnt);
                pend = 1'b1;
                wcnt = slv_wait;
                if (bus.rd) nxt = (rdq.size() > 0) ? rdq.pop_front() : 32'hBAD0BAD0;
                else nxt = '0;
            end
            if (bus.wb_ack) begin
                ack_dat.push_back(bus.wb_dat_o);
                ack_cyc.push_back(cyc_cnt);
            end
            if (bus.irq) irq_cyc.push_back(cyc_cnt);
            if (!rst && bus.rd && bus.we) begin
                checks++;
                errors++;
                $display("FAIL rd_we_both: rd=%0b we=%0b required not both high", bus.rd, bus.we);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        p_addr.delete(); p_data.delete(); p_we.delete(); p_cyc.delete();
        ack_dat.delete(); ack_cyc.delete(); irq_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one request starting at a negedge; returns at the negedge after acceptance.
    task automatic wb_req(input bit w, input logic [31:0] adr, input logic [31:0] dat, output int acc);
        int budget;
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = w;
        bus.wb_addr = adr; bus.wb_dat_i = dat;
        #1;
        budget = 50;
        while (bus.wb_stall && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        acc = cyc_cnt;
        @(negedge clk);
        bus.wb_stb = 1'b0;
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL accept_timeout: stall still %0b, required 0 within 50 cycles", bus.wb_stall);
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        while (ack_dat.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (ack_dat.size() < n) begin
            errors++;
            $display("FAIL ack_timeout: got %0d acks, required %0d", ack_dat.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_addr = '0; bus.wb_dat_i = '0; bus.wb_sel = '1;
        idle(3);
        #1;
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b required 0", bus.wb_stall); end
        checks++; if (bus.wb_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %0b required 0", bus.wb_ack); end
        checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h required 0", bus.wb_dat_o); end
        checks++; if (bus.a !== 32'h0) begin errors++; $display("FAIL rst_a: got %h required 0", bus.a); end
        checks++; if (bus.d !== 32'h0) begin errors++; $display("FAIL rst_d: got %h required 0", bus.d); end
        checks++; if (bus.rd !== 1'b0 || bus.we !== 1'b0) begin errors++; $display("FAIL rst_strobe: rd=%0b we=%0b required 0", bus.rd, bus.we); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b required 0", bus.irq); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int acc;
        clear_logs();
        slv_wait = 3;
        rdq.push_back(32'hCAFEF00D);
        wb_req(1'b0, 32'h1000_0004, 32'h0, acc);
        wait_acks(1, 40);
        idle(4);
        checks++; if (p_addr.size() != 1) begin errors++; $display("FAIL sr_pulses: got %0d required 1", p_addr.size()); end
        checks++; if (p_we[0] !== 1'b0) begin errors++; $display("FAIL sr_kind: we=%0b required 0", p_we[0]); end
        checks++; if (p_addr[0] !== 32'h1000_0004) begin errors++; $display("FAIL sr_addr: got %h required 10000004", p_addr[0]); end
        checks++; if (p_cyc[0] != acc + 1) begin errors++; $display("FAIL sr_issue_cyc: got %0d required %0d", p_cyc[0], acc + 1); end
        checks++; if (ack_dat.size() != 1) begin errors++; $display("FAIL sr_acks: got %0d required 1", ack_dat.size()); end
        checks++; if (ack_dat[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL sr_data: got %h required cafef00d", ack_dat[0]); end
        checks++; if (ack_cyc[0] != rise_cyc + 1) begin errors++; $display("FAIL sr_ack_after_ready: got %0d required %0d", ack_cyc[0], rise_cyc + 1); end
        checks++; if (ack_cyc[0] != p_cyc[0] + 5) begin errors++; $display("FAIL sr_ack_cyc: got %0d required %0d", ack_cyc[0], p_cyc[0] + 5); end
    endtask

    task automatic test_min_latency();
        int acc;
        clear_logs();
        slv_wait = 1;
        wb_req(1'b1, 32'h0000_0200, 32'h0000_1234, acc);
        wait_acks(1, 20);
        idle(3);
        checks++; if (ack_cyc[0] != acc + 4) begin errors++; $display("FAIL ml_latency: got %0d required %0d", ack_cyc[0] - acc, 4); end
        checks++; if (p_we[0] !== 1'b1 || p_data[0] !== 32'h1234) begin errors++; $display("FAIL ml_write: we=%0b d=%h required 1/00001234", p_we[0], p_data[0]); end
        checks++; if (ack_dat[0] !== 32'h0) begin errors++; $display("FAIL ml_wdata: got %h required 0", ack_dat[0]); end
    endtask

    task automatic test_pipelined_writes();
        int budget;
        clear_logs();
        slv_wait = 1;
        slv_hold = 1'b1;
        @(negedge clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_addr = 32'h0; bus.wb_dat_i = 32'h10;
        #1;
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL pw_stall1: got %0b required 0", bus.wb_stall); end
        @(negedge clk);
        bus.wb_addr = 32'h4; bus.wb_dat_i = 32'h11;
        #1;
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL pw_stall2: got %0b required 0", bus.wb_stall); end
        @(negedge clk);
        bus.wb_addr = 32'h8; bus.wb_dat_i = 32'h12;
        #1;
        checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL pw_stall3: got %0b required 1", bus.wb_stall); end
        slv_hold = 1'b0;
        budget = 20;
        while (bus.wb_stall && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        @(negedge clk);
        bus.wb_stb = 1'b0;
        wait_acks(3, 60);
        idle(4);
        checks++; if (p_addr.size() != 3) begin errors++; $display("FAIL pw_pulses: got %0d required 3", p_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (p_addr[i] !== 32'(i * 4) || p_data[i] !== 32'(16 + i) || p_we[i] !== 1'b1) begin
                errors++;
                $display("FAIL pw_order%0d: a=%h d=%h we=%0b required %h/%h/1", i, p_addr[i], p_data[i], p_we[i], i * 4, 16 + i);
            end
        end
        checks++; if (ack_dat.size() != 3) begin errors++; $display("FAIL pw_acks: got %0d required 3", ack_dat.size()); end
        checks++; if (ack_cyc[1] <= ack_cyc[0] || ack_cyc[2] <= ack_cyc[1]) begin errors++; $display("FAIL pw_ack_pulses: cycles %0d %0d %0d required increasing", ack_cyc[0], ack_cyc[1], ack_cyc[2]); end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [31:0] exp_dat [3];
        bit exp_we [3];
        exp_dat[0] = 32'hA; exp_dat[1] = 32'h0; exp_dat[2] = 32'hB;
        exp_we[0] = 1'b0; exp_we[1] = 1'b1; exp_we[2] = 1'b0;
        clear_logs();
        slv_wait = 1;
        rdq.push_back(32'hA);
        rdq.push_back(32'hB);
        wb_req(1'b0, 32'h20, 32'h0, acc);
        wb_req(1'b1, 32'h24, 32'h55, acc);
        wb_req(1'b0, 32'h28, 32'h0, acc);
        wait_acks(3, 40);
        idle(4);
        checks++; if (ack_dat.size() != 3) begin errors++; $display("FAIL bb_acks: got %0d required 3", ack_dat.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ack_dat[i] !== exp_dat[i] || p_we[i] !== exp_we[i]) begin
                errors++;
                $display("FAIL bb_seq%0d: data=%h we=%0b required %h/%0b", i, ack_dat[i], p_we[i], exp_dat[i], exp_we[i]);
            end
        end
        checks++; if (p_cyc[1] - p_cyc[0] != 3) begin errors++; $display("FAIL bb_rate: gap %0d required 3", p_cyc[1] - p_cyc[0]); end
        checks++; if (p_cyc[1] != ack_cyc[0]) begin errors++; $display("FAIL bb_issue_on_ack: pulse %0d required %0d", p_cyc[1], ack_cyc[0]); end
    endtask

    task automatic test_abort();
        int acc;
        clear_logs();
        slv_wait = 6;
        rdq.push_back(32'h11);
        wb_req(1'b0, 32'h30, 32'h0, acc);
        wb_req(1'b0, 32'h34, 32'h0, acc);
        bus.wb_cyc = 1'b0;
        idle(14);
        checks++; if (p_addr.size() != 1 || p_addr[0] !== 32'h30) begin errors++; $display("FAIL ab_issued: got %0d pulses, first %h, required 1 at 00000030", p_addr.size(), p_addr[0]); end
        checks++; if (ack_dat.size() != 0) begin errors++; $display("FAIL ab_no_ack: got %0d acks required 0", ack_dat.size()); end
        rdq.push_back(32'h77);
        slv_wait = 1;
        wb_req(1'b0, 32'h38, 32'h0, acc);
        wait_acks(1, 20);
        idle(3);
        checks++; if (p_addr.size() != 2 || p_addr[1] !== 32'h38) begin errors++; $display("FAIL ab_next_issue: got %0d pulses, last %h, required 2 at 00000038", p_addr.size(), p_addr[1]); end
        checks++; if (ack_dat[0] !== 32'h77) begin errors++; $display("FAIL ab_next_data: got %h required 00000077", ack_dat[0]); end
        checks++; if (ack_cyc[0] != acc + 4) begin errors++; $display("FAIL ab_next_latency: got %0d required 4", ack_cyc[0] - acc); end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_logs();
        slv_wait = 20;
        wb_req(1'b0, 32'h40, 32'h0, acc);
        wb_req(1'b0, 32'h44, 32'h0, acc);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.a !== 32'h0 || bus.d !== 32'h0) begin errors++; $display("FAIL rm_ad: a=%h d=%h required 0", bus.a, bus.d); end
        checks++; if (bus.rd !== 1'b0 || bus.we !== 1'b0) begin errors++; $display("FAIL rm_strobe: rd=%0b we=%0b required 0", bus.rd, bus.we); end
        checks++; if (bus.wb_ack !== 1'b0 || bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rm_ack: ack=%0b dat=%h required 0", bus.wb_ack, bus.wb_dat_o); end
        checks++; if (bus.wb_stall !== 1'b0 || bus.irq !== 1'b0) begin errors++; $display("FAIL rm_stall_irq: stall=%0b irq=%0b required 0", bus.wb_stall, bus.irq); end
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        checks++; if (p_addr.size() != 1) begin errors++; $display("FAIL rm_fifo_empty: got %0d pulses required 1", p_addr.size()); end
        checks++; if (ack_dat.size() != 0) begin errors++; $display("FAIL rm_no_ack: got %0d acks required 0", ack_dat.size()); end
        bus.wb_cyc = 1'b0;
        slv_wait = 1;
        idle(2);
    endtask

`ifdef WB2MM_TIMEOUT_EN
    task automatic test_timeout();
        int acc;
        int budget;
        int r1;
        clear_logs();
        slv_wait = 1;
        slv_hang = 1'b1;
        rdq.push_back(32'h1);
        rdq.push_back(32'h99);
        wb_req(1'b0, 32'h50, 32'h0, acc);
        wb_req(1'b0, 32'h54, 32'h0, acc);
        idle(14);
        checks++; if (ack_dat.size() != 1 || ack_dat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL to_ack: got %0d acks, data %h, required 1 deadbeef", ack_dat.size(), ack_dat[0]); end
        checks++; if (ack_cyc[0] != p_cyc[0] + 9) begin errors++; $display("FAIL to_ack_cyc: got %0d required %0d", ack_cyc[0], p_cyc[0] + 9); end
        checks++; if (irq_cyc.size() != 1 || irq_cyc[0] != p_cyc[0] + 9) begin errors++; $display("FAIL to_irq: got %0d pulses at %0d required 1 at %0d", irq_cyc.size(), irq_cyc[0], p_cyc[0] + 9); end
        checks++; if (p_addr.size() != 1) begin errors++; $display("FAIL to_drain_hold: got %0d pulses required 1", p_addr.size()); end
        slv_hang = 1'b0;
        budget = 20;
        while (p_addr.size() < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        r1 = rise_cyc;
        checks++; if (p_addr.size() != 2 || p_cyc[1] != r1 + 1) begin errors++; $display("FAIL to_resume: got %0d pulses, at %0d, required 2 at %0d", p_addr.size(), p_cyc[1], r1 + 1); end
        wait_acks(2, 20);
        idle(3);
        checks++; if (ack_dat[1] !== 32'h99) begin errors++; $display("FAIL to_next_data: got %h required 00000099", ack_dat[1]); end
        bus.wb_cyc = 1'b0;
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_min_latency();
        test_pipelined_writes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef WB2MM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb2mm.md
# wb2mm

Pipelined Wishbone slave that converts Wishbone B4 pipelined transactions into single-outstanding requests on the internal quasiSoC memory-mapped (mm) bus (`a`/`d`/`we`/`rd`/`spo`/`ready`). It sits directly downstream of the `mm2wb` master or interconnect and fronts legacy mm peripherals (UART, GPIO, boot ROM) so they can be reached from Wishbone. It contains a small request FIFO, so the master can pipeline requests, and it returns acks strictly in request order.

## Interface
Parameters:
- `ADDRLEN`, 32, Wishbone/mm address width.
- `DATALEN`, 32, data width. Only 32 is supported.
- `FIFO_DEPTH`, 2, number of request FIFO entries. Must be a power of two and at least 2.
- `TIMEOUT_CYCLES`, 1023, cycles to wait for mm `ready` before declaring a timeout (only with `WB2MM_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wb_cyc`  in  1  Wishbone bus cycle.
- `wb_stb`  in  1  Wishbone strobe.
- `wb_we`  in  1  Wishbone write enable.
- `wb_addr`  in  ADDRLEN  Wishbone address.
- `wb_dat_i`  in  DATALEN  Wishbone write data.
- `wb_sel`  in  DATALEN/8  byte select. Ignored; every access is a full word.
- `wb_stall`  out  1  high when the FIFO is full.
- `wb_ack`  out  1  one-cycle ack per accepted request.
- `wb_dat_o`  out  DATALEN  read data, valid while `wb_ack` is high.
- `a`  out  32  mm address.
- `d`  out  32  mm write data.
- `we`  out  1  mm write pulse.
- `rd`  out  1  mm read pulse.
- `spo`  in  32  mm read data, valid while `ready` is high.
- `ready`  in  1  mm slave idle / transaction complete.
- `irq`  out  1  timeout pulse.

## Operation
- **Accept:** a request is accepted on any cycle with `wb_cyc & wb_stb & !wb_stall`. The FIFO pushes {`wb_we`, `wb_addr`, `wb_dat_i`}.
- **Stall:** `wb_stall = (count == FIFO_DEPTH)`. It is combinational from the registered count only. A pop in the same cycle does not lift the stall.
- **Simultaneous push and pop:** count is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- **Issue FSM states:** IDLE, WAIT, DRAIN.
  - IDLE: if the FIFO is non-empty and `ready` is high, pop the head entry. Drive `a`/`d` and pulse `rd` (read) or `we` (write) high for exactly one cycle, then go to WAIT.
  - WAIT: ignore `ready` in the first cycle after the pulse. The mm slave guarantees `ready` is low in that cycle. From the second cycle on, `ready` high means complete: register `wb_ack=1` and `wb_dat_o = spo` for a read or 0 for a write, then go to IDLE.
- **Outputs:** `a`/`d` hold their last values between transactions. `rd`/`we` are never both high.
- **Abort:** if `wb_cyc` is low while the FIFO is non-empty or the FSM is in WAIT, all unissued FIFO entries are flushed. An in-flight mm transaction runs to completion, but its `wb_ack` is suppressed (an abort flag is set in WAIT and cleared on return to IDLE).
- **Reset:** FIFO empty, FSM in IDLE, abort flag cleared, timeout counter cleared. `wb_stall=0`, `wb_ack=0`, `wb_dat_o=0`, `a=0`, `d=0`, `rd=0`, `we=0`, `irq=0`.
- **Reset mid-transaction:** this block returns to IDLE immediately. The mm slave shares `rst` and is reset too. No ack is produced.

## Timing
- **Accept to first visible entry:** a request accepted at cycle N is visible in the FIFO at N+1. The `rd`/`we` pulse occurs at N+1 at the earliest (IDLE, `ready` high).
- **Completion:** if `ready` is sampled high at cycle M, then `wb_ack` is high at M+1.
- **Minimum latency:** with a zero-wait mm slave (`ready` high again at pulse+2), the minimum accept-to-ack latency is 4 cycles.
- **Throughput:** back-to-back issue at best one transaction per 3 cycles. The next pulse may occur in the cycle `wb_ack` is high.
- **Ack rate:** `wb_ack` is a single-cycle pulse, at most one per cycle, in strict FIFO order.

## Configuration
- **`WB2MM_TIMEOUT_EN` defined:**
  - A 10-bit (clog2 `TIMEOUT_CYCLES+1`) counter runs in WAIT.
  - When it reaches `TIMEOUT_CYCLES`, the block acks with `wb_dat_o=32'hDEADBEEF`, pulses `irq` for one cycle, and goes to DRAIN.
  - DRAIN waits for `ready` high with no ack, then goes to IDLE.
- **Undefined:** no counter, no DRAIN state, and `irq` is tied to 0. WAIT waits forever.

## Structure
- **Package `wb2mm_pkg`:** state enum (IDLE/WAIT/DRAIN), request struct {we, addr, data}, constant `WB2MM_TIMEOUT_DATA = 32'hDEADBEEF`.
- **Sub-module `wb2mm_fifo`:** synchronous FIFO with `push`, `pop`, `flush`, `count`, `full`, `empty`. Registered pointers, first-word-fall-through head.

## Test plan
- **Single read:** read of `0x1000_0004`, slave returns `0xCAFEF00D` after 3 wait cycles -> one `rd` pulse with `a=0x1000_0004`; `wb_ack` with `wb_dat_o=0xCAFEF00D` one cycle after `ready` rises.
- **Pipelined writes:** 3 back-to-back writes (`0x10`/`0x11`/`0x12` to addresses 0/4/8) -> `wb_stall` high on the third cycle (`DEPTH=2`); mm sees 3 `we` pulses in order; 3 acks in order.
- **Mixed order:** mixed read/write/read with reads returning 0xA and 0xB -> ack data sequence 0xA, 0, 0xB.
- **Abort:** `wb_cyc` dropped during WAIT with 1 entry queued -> queued entry never issued; no `wb_ack`; FSM in IDLE after `ready`.
- **Timeout:** `WB2MM_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, slave never readies -> at pulse+9, `wb_ack` with `0xDEADBEEF` and a one-cycle `irq`; next request not issued until `ready` rises.
- **Reset mid-operation:** `rst` asserted in WAIT -> all outputs at reset values next cycle; FIFO empty.
